clock_set_controller: RTL

Sequencing controller for the hour/min/sec timekeeping block. It generates the one-second tick from the system clock. It runs a RUN/SET_HOUR/SET_MIN/SET_SEC mode machine from a mode button, and turns up/down buttons into step commands with auto-repeat. It drives the timekeeper's on/set/sethms/upDown inputs and provides a blink enable for the display of the selected field.

---
 rtl/clock_set_controller.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_set_controller.sv
// clock_set_controller
//    Sequencing controller for the hour/min/sec timekeeper. Generates the
//    one-second tick, runs the RUN/SET_HOUR/SET_MIN/SET_SEC mode machine from
//    the mode button, turns up/down buttons into step strobes with auto-repeat,
//    and produces a blink enable for the field being set.
//
// Ports
//    clk         system clock
//    rst         synchronous reset, active-high
//    enable      run switch level
//    modeBtn     mode button level (clean)
//    upBtn       up button level (clean)
//    downBtn     down button level (clean)
//    oneSecTick  one-cycle pulse per CLK_HZ cycles while running
//    on          timekeeper run enable
//    set         step strobe, toggles once per step
//    sethms      field select, equals the state code (11 = none)
//    upDown      10 up, 01 down, 00 idle
//    blink       display blink enable for the selected field
//    setMode     high in any SET state
//
// state    | meaning
// ---------+-----------------------------------------------
// RUN      | timekeeping, tick prescaler active when enabled
// SET_HOUR | hour field selected for stepping
// SET_MIN  | minute field selected for stepping
// SET_SEC  | second field selected for stepping

module clock_set_controller #(
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 5000000,
   parameter int unsigned TIMEOUT_CYC  = 500000000,
   parameter int unsigned BLINK_HALF   = 12500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       modeBtn,
   input  logic       upBtn,
   input  logic       downBtn,
   output logic       oneSecTick,
   output logic       on,
   output logic       set,
   output logic [1:0] sethms,
   output logic [1:0] upDown,
   output logic       blink,
   output logic       setMode
);

   typedef enum logic [1:0] {
      SET_HOUR = 2'b00,
      SET_MIN  = 2'b01,
      SET_SEC  = 2'b10,
      RUN      = 2'b11
   } state_t;

   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int PW = (CLK_HZ > 1)      ? $clog2(CLK_HZ)      : 1;
   localparam int RW = (RMAX > 1)        ? $clog2(RMAX)        : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int BW = (BLINK_HALF > 1)  ? $clog2(BLINK_HALF)  : 1;

   // step phases: DRIVE is cycle S (direction presented), STROBE is S+1 (set toggled)
   localparam logic [1:0] PH_IDLE   = 2'd0;
   localparam logic [1:0] PH_DRIVE  = 2'd1;
   localparam logic [1:0] PH_STROBE = 2'd2;

   state_t          state, state_nxt;
   logic            mode_q, up_q, dn_q;
   logic [PW-1:0]   presc;
   logic            mode_pend;
   logic [1:0]      step_ph;
   logic            armed, rep, rep_up;
   logic [RW-1:0]   rpt;
   logic [TW-1:0]   idle;
   logic [BW-1:0]   blk, blk_nxt;
   logic            blink_ph, blink_ph_nxt;

   logic            in_set, in_flight, mode_req, advance, timeout_hit, to_run, state_chg;
   logic            single_up, single_dn, edge_up, edge_dn;
   logic            rpt_hold, rpt_fire, can_step, trig, trig_up, busy_nxt;
   logic [RW-1:0]   rpt_lim;

   assign sethms = state;

   always_ff @(posedge clk) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      in_set      = (state != RUN);
      in_flight   = (step_ph != PH_IDLE);
      // a mode edge seen during a step is remembered and applied once the step is done
      mode_req    = (modeBtn & ~mode_q) | mode_pend;
      advance     = mode_req & ~in_flight;
      timeout_hit = in_set & (idle == TW'(TIMEOUT_CYC - 1));
      to_run      = timeout_hit & ~in_flight;

      state_nxt = state;
      if (advance) begin
         case (state)
            RUN:      state_nxt = SET_HOUR;
            SET_HOUR: state_nxt = SET_MIN;
            SET_MIN:  state_nxt = SET_SEC;
            default:  state_nxt = RUN;
         endcase
      end else if (to_run) begin
         state_nxt = RUN;
      end
      state_chg = (state_nxt != state);

      single_up = upBtn & ~downBtn;
      single_dn = downBtn & ~upBtn;
      edge_up   = single_up & ~up_q;
      edge_dn   = single_dn & ~dn_q;

      rpt_lim  = rep ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
      rpt_hold = armed & (rep_up ? single_up : single_dn);
      rpt_fire = rpt_hold & (rpt == rpt_lim);

      // a new step may start in the STROBE cycle so repeats can run back-to-back;
      // direction then simply stays on upDown across the joined steps
      can_step = in_set & ~mode_req & ~timeout_hit & (step_ph != PH_DRIVE);
      trig     = can_step & (edge_up | edge_dn | rpt_fire);
      trig_up  = edge_up | (~edge_dn & rpt_fire & rep_up);
      busy_nxt = trig | (step_ph == PH_DRIVE);

      blk_nxt      = '0;
      blink_ph_nxt = 1'b0;
      if (state_nxt == RUN) begin
         blink_ph_nxt = 1'b0;
      end else if (state_chg) begin
         blink_ph_nxt = 1'b1;
      end else if (blk == BW'(BLINK_HALF - 1)) begin
         blink_ph_nxt = ~blink_ph;
      end else begin
         blk_nxt      = blk + 1'b1;
         blink_ph_nxt = blink_ph;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q     <= 1'b0;
         up_q       <= 1'b0;
         dn_q       <= 1'b0;
         presc      <= '0;
         oneSecTick <= 1'b0;
         on         <= 1'b0;
         mode_pend  <= 1'b0;
         step_ph    <= PH_IDLE;
         set        <= 1'b0;
         upDown     <= 2'b00;
         armed      <= 1'b0;
         rep        <= 1'b0;
         rep_up     <= 1'b0;
         rpt        <= '0;
         idle       <= '0;
         blk        <= '0;
         blink_ph   <= 1'b0;
         blink      <= 1'b0;
         setMode    <= 1'b0;
      end else begin
         mode_q <= modeBtn;
         up_q   <= upBtn;
         dn_q   <= downBtn;

         on <= enable & (state == RUN);

         if (!on) begin
            presc      <= '0;
            oneSecTick <= 1'b0;
         end else if (presc == PW'(CLK_HZ - 1)) begin
            presc      <= '0;
            oneSecTick <= 1'b1;
         end else begin
            presc      <= presc + 1'b1;
            oneSecTick <= 1'b0;
         end

         mode_pend <= mode_req & in_flight;

         if (step_ph == PH_DRIVE) begin
            set     <= ~set;
            step_ph <= PH_STROBE;
         end else if (trig) begin
            upDown  <= trig_up ? 2'b10 : 2'b01;
            step_ph <= PH_DRIVE;
         end else if (step_ph == PH_STROBE) begin
            upDown  <= 2'b00;
            step_ph <= PH_IDLE;
         end

         // armed marks a hold that started with an accepted press in this state;
         // losing it forces a release and re-press before stepping again
         if (!in_set || state_chg) begin
            armed <= 1'b0;
            rep   <= 1'b0;
            rpt   <= '0;
         end else if (trig) begin
            armed  <= 1'b1;
            rep    <= ~(edge_up | edge_dn);
            rep_up <= trig_up;
            rpt    <= '0;
         end else if (rpt_hold) begin
            if (rpt != rpt_lim) rpt <= rpt + 1'b1;
         end else begin
            armed <= 1'b0;
            rep   <= 1'b0;
            rpt   <= '0;
         end

         if (!in_set || state_chg || modeBtn || upBtn || downBtn) idle <= '0;
         else if (!timeout_hit)                                   idle <= idle + 1'b1;

         blk      <= blk_nxt;
         blink_ph <= blink_ph_nxt;
         blink    <= (state_nxt != RUN) & (blink_ph_nxt | busy_nxt | upBtn | downBtn);
         setMode  <= (state_nxt != RUN);
      end
   end

endmodule
